// File: rtl/bus_read_responder_if.sv
// bus_read_responder_if: single-outstanding read handshake between fetch (master) and memory (slave)
interface bus_read_responder_if;
  logic        bus_read_vaild;
  logic [31:0] bus_read_address;
  logic        bus_read_ready;
  logic [31:0] bus_read_data;
  modport master (output bus_read_vaild, bus_read_address, input bus_read_ready, bus_read_data);
  modport slave (input bus_read_vaild, bus_read_address, output bus_read_ready, bus_read_data);
endinterface

// File: rtl/bus_read_responder.sv
// bus_read_responder: wait-stated DEPTH x 32 word memory answering the fetch read handshake, with a backdoor load port
module bus_read_responder #(
  parameter int          DEPTH      = 1024,
  parameter int          LATENCY    = 2,
  parameter logic [31:0] ERROR_DATA = 32'h0000_0000
) (
  input  logic                 clock,
  input  logic                 reset_n,
  bus_read_responder_if.slave  bus,
  input  logic                 load_valid,
  input  logic [31:0]          load_address,
  input  logic [31:0]          load_data,
  output logic                 error_sticky
);
  localparam int CW = LATENCY > 0 ? $clog2(LATENCY + 1) : 1;
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, RESPOND, RELEASE} state_t;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_addr, r_data, w_rd_addr, w_rd_data;
  logic          r_ready, r_err, w_rd_ok, w_load_ok, w_capture;
  logic [31:0]   r_mem [DEPTH];
  // With zero latency the capture happens on the accepting edge, so the live bus address is used.
  always_comb begin
    w_rd_addr = (r_state == IDLE) ? bus.bus_read_address : r_addr;
    w_rd_ok   = w_rd_addr < 32'(DEPTH);
    w_rd_data = w_rd_ok ? r_mem[w_rd_addr[AW-1:0]] : ERROR_DATA;
    w_load_ok = load_address < 32'(DEPTH);
    w_capture = (LATENCY == 0) ? (r_state == IDLE && bus.bus_read_vaild) : (r_state == WAIT && r_cnt == CW'(1));
  end
  always_ff @(posedge clock) begin
    if (load_valid && w_load_ok) r_mem[load_address[AW-1:0]] <= load_data;
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_ready <= 1'b0;
      r_data  <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
      r_addr  <= '0;
    end else begin
      r_ready <= w_capture;
      if (w_capture) r_data <= w_rd_data;
      if ((w_capture && !w_rd_ok) || (load_valid && !w_load_ok)) r_err <= 1'b1;
      case (r_state)
        IDLE: if (bus.bus_read_vaild) begin
          r_addr  <= bus.bus_read_address;
          r_cnt   <= CW'(LATENCY);
          r_state <= (LATENCY == 0) ? RESPOND : WAIT;
        end
        WAIT: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) r_state <= RESPOND;
        end
        RESPOND: r_state <= RELEASE;
        RELEASE: if (!bus.bus_read_vaild) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.bus_read_ready = r_ready;
  assign bus.bus_read_data  = r_data;
  assign error_sticky       = r_err;
endmodule

// File: tb/tb_bus_read_responder.sv
// tb_bus_read_responder: random and directed reads on LATENCY=2 and LATENCY=0 responders against an array model
module tb_bus_read_responder;
  localparam int DEPTH = 1024;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic        rst_n, lv;
  logic [31:0] la, ld;
  logic        vld [2];
  logic [31:0] adr [2];
  logic        rdy [2];
  logic [31:0] dat [2];
  logic        err [2];
  bus_read_responder_if bif_a();
  bus_read_responder_if bif_b();
  assign bif_a.bus_read_vaild   = vld[0];
  assign bif_a.bus_read_address = adr[0];
  assign bif_b.bus_read_vaild   = vld[1];
  assign bif_b.bus_read_address = adr[1];
  assign rdy[0] = bif_a.bus_read_ready;
  assign dat[0] = bif_a.bus_read_data;
  assign rdy[1] = bif_b.bus_read_ready;
  assign dat[1] = bif_b.bus_read_data;
  bus_read_responder #(.DEPTH(DEPTH), .LATENCY(2)) dut_a (
    .clock(clk), .reset_n(rst_n), .bus(bif_a.slave), .load_valid(lv),
    .load_address(la), .load_data(ld), .error_sticky(err[0]));
  bus_read_responder #(.DEPTH(DEPTH), .LATENCY(0)) dut_b (
    .clock(clk), .reset_n(rst_n), .bus(bif_b.slave), .load_valid(lv),
    .load_address(la), .load_data(ld), .error_sticky(err[1]));
  logic [31:0] mem [DEPTH];
  bit          errm [2];
  int          checks = 0, failures = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask
  task automatic load(input logic [31:0] a, input logic [31:0] d);
    lv = 1'b1; la = a; ld = d;
    @(posedge clk); #1;
    lv = 1'b0;
    if (a < 32'(DEPTH)) mem[a] = d;
    else begin errm[0] = 1'b1; errm[1] = 1'b1; end
  endtask
  // One fetch-style read; coll loads cdata into the same word on the capture edge.
  task automatic rd(input int w, input logic [31:0] addr, input int hold, input bit coll, input logic [31:0] cdata, output int t_rdy);
    int lat = (w == 0) ? 2 : 0;
    bit oob = addr >= 32'(DEPTH);
    logic [31:0] exp = oob ? 32'h0 : mem[addr];
    vld[w] = 1'b1; adr[w] = addr;
    for (int k = 0; k <= lat; k++) begin
      if (coll && k == lat) begin lv = 1'b1; la = addr; ld = cdata; end
      @(posedge clk); #1;
      lv = 1'b0;
      if (k == 0) adr[w] = $urandom;
      if (k < lat) check("early_ready", 32'(rdy[w]), 0);
    end
    if (coll && !oob) mem[addr] = cdata;
    if (oob) errm[w] = 1'b1;
    t_rdy = cyc;
    check("ready", 32'(rdy[w]), 1);
    check("data", dat[w], exp);
    check("error_sticky", 32'(err[w]), 32'(errm[w]));
    repeat (hold) begin @(posedge clk); #1; check("hold_ready", 32'(rdy[w]), 0); end
    vld[w] = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      check("release_ready", 32'(rdy[w]), 0);
      check("data_hold", dat[w], exp);
    end
  endtask
  initial begin
    int t1, t2, w, r, h;
    logic [31:0] a;
    rst_n = 1'b0; lv = 1'b0; la = '0; ld = '0;
    vld[0] = 1'b0; vld[1] = 1'b0; adr[0] = '0; adr[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check("reset_ready", 32'(rdy[i]), 0);
      check("reset_data", dat[i], 0);
      check("reset_err", 32'(err[i]), 0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) load(32'(i), $urandom);
    load(5, 32'hDEAD_BEEF);
    rd(0, 5, 0, 0, 0, t1);
    load(0, 32'h1234_5678);
    rd(1, 0, 0, 0, 0, t1);
    rd(1, 0, 0, 0, 0, t2);
    check("b2b_spacing", 32'(t2 - t1), 3);
    rd(0, 9, 4, 0, 0, t1);
    rd(0, 10, 0, 0, 0, t1);
    rd(1, 11, 4, 0, 0, t1);
    rd(1, 12, 0, 0, 0, t1);
    rd(0, 32'(DEPTH), 0, 0, 0, t1);
    rd(0, 3, 0, 0, 0, t1);
    rd(1, 3, 0, 0, 0, t1);
    rd(0, 32'h0001_0005, 0, 0, 0, t1);
    load(32'h8000_0005, 32'h5555_5555);
    rd(1, 4, 0, 0, 0, t1);
    load(7, 32'h0BAD_0007);
    rd(0, 7, 0, 1, 32'hAAAA_0001, t1);
    rd(0, 7, 0, 0, 0, t1);
    rd(1, 8, 0, 1, 32'hAAAA_0002, t1);
    rd(1, 8, 0, 0, 0, t1);
    vld[0] = 1'b1; adr[0] = 5;
    @(posedge clk); #1;
    rst_n = 1'b0; vld[0] = 1'b0;
    @(posedge clk); #1;
    errm[0] = 1'b0; errm[1] = 1'b0;
    check("midreset_ready", 32'(rdy[0]), 0);
    check("midreset_data", dat[0], 0);
    check("midreset_err", 32'(err[0]), 0);
    check("midreset_err_b", 32'(err[1]), 0);
    rst_n = 1'b1;
    repeat (4) begin @(posedge clk); #1; check("abandoned_ready", 32'(rdy[0]), 0); end
    rd(0, 5, 0, 0, 0, t1);
    for (int i = 0; i < 80; i++) begin
      w = $urandom_range(0, 1);
      r = $urandom_range(0, 9);
      h = $urandom_range(0, 2);
      if (r == 0) load($urandom_range(0, DEPTH - 1), $urandom);
      if (r == 1) a = ($urandom_range(0, 1) == 1) ? 32'(DEPTH) + 32'($urandom_range(0, 100)) : ($urandom | 32'h8000_0000);
      else a = 32'($urandom_range(0, DEPTH - 1));
      rd(w, a, h, r == 2, $urandom, t1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
